// File: rtl/register_file_sb.sv
// register_file_sb
//   MIPS general-purpose register file with a registered read path.
//   Two read ports, one write port, optional hardwired zero register,
//   optional write-to-read bypass and a per-register pending (scoreboard)
//   bit. Results appear one cycle after ReadEnable, qualified by ReadValid.
//
// Ports
//   Clock          in   single clock, rising edge
//   Reset          in   synchronous, active-high; clears registers, pending bits, outputs
//   RegWrite       in   write enable; also clears the pending bit of WriteRegister
//   WriteRegister  in   write index
//   WriteData      in   write data
//   ReadEnable     in   launch a read of both ports
//   ReadRegister1  in   port-1 read index
//   ReadRegister2  in   port-2 read index
//   PendSet        in   mark PendRegister as awaiting writeback
//   PendRegister   in   index whose pending bit is set
//   ReadData1      out  registered port-1 data
//   ReadData2      out  registered port-2 data
//   ReadValid      out  high the cycle after an accepted read
//   Busy1          out  registered pending state of the port-1 register
//   Busy2          out  registered pending state of the port-2 register
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              ReadEnable,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic              PendSet,
  input  logic [ADDR_W-1:0] PendRegister,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ReadValid,
  output logic              Busy1,
  output logic              Busy2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic              wr_en;
  logic [DATA_W-1:0] rd1_nxt;
  logic [DATA_W-1:0] rd2_nxt;

  function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
    return ZERO_REG && (idx == '0);
  endfunction

  // Writes to the hardwired zero register never reach the array.
  assign wr_en = RegWrite && !is_zero(WriteRegister);

  // Scoreboard next state: a new producer (PendSet) wins over a writeback
  // to the same index in the same cycle.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_nxt[i] = (PendSet && (PendRegister == ADDR_W'(i))) ||
                    (pend[i] && !(RegWrite && (WriteRegister == ADDR_W'(i))));
    end
    if (ZERO_REG) pend_nxt[0] = 1'b0;
  end

  // Zero register beats bypass; bypass beats the stored value.
  always_comb begin
    rd1_nxt = mem[ReadRegister1];
    rd2_nxt = mem[ReadRegister2];
    if (BYPASS && wr_en && (WriteRegister == ReadRegister1)) rd1_nxt = WriteData;
    if (BYPASS && wr_en && (WriteRegister == ReadRegister2)) rd2_nxt = WriteData;
    if (is_zero(ReadRegister1)) rd1_nxt = '0;
    if (is_zero(ReadRegister2)) rd2_nxt = '0;
  end

  // Single register stage: array, scoreboard and read outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend      <= '0;
      ReadData1 <= '0;
      ReadData2 <= '0;
      ReadValid <= 1'b0;
      Busy1     <= 1'b0;
      Busy2     <= 1'b0;
    end else begin
      if (wr_en) mem[WriteRegister] <= WriteData;
      pend      <= pend_nxt;
      ReadValid <= ReadEnable;
      if (ReadEnable) begin
        ReadData1 <= rd1_nxt;
        ReadData2 <= rd2_nxt;
        Busy1     <= pend_nxt[ReadRegister1];
        Busy2     <= pend_nxt[ReadRegister2];
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        read_enable;
  logic [4:0]  read_register1;
  logic [4:0]  read_register2;
  logic        pend_set;
  logic [4:0]  pend_register;

  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        rv, b1, b2, nb_rv, nb_b1, nb_b2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .Clock(clk), .Reset(rst), .RegWrite(reg_write), .WriteRegister(write_register),
    .WriteData(write_data), .ReadEnable(read_enable), .ReadRegister1(read_register1),
    .ReadRegister2(read_register2), .PendSet(pend_set), .PendRegister(pend_register),
    .ReadData1(rd1), .ReadData2(rd2), .ReadValid(rv), .Busy1(b1), .Busy2(b2)
  );

  register_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .Clock(clk), .Reset(rst), .RegWrite(reg_write), .WriteRegister(write_register),
    .WriteData(write_data), .ReadEnable(read_enable), .ReadRegister1(read_register1),
    .ReadRegister2(read_register2), .PendSet(pend_set), .PendRegister(pend_register),
    .ReadData1(nb_rd1), .ReadData2(nb_rd2), .ReadValid(nb_rv), .Busy1(nb_b1), .Busy2(nb_b2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    reg_write = 1'b0; read_enable = 1'b0; pend_set = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    write_register = '0; write_data = '0;
    read_register1 = '0; read_register2 = '0; pend_register = '0;
    step(); step();
    chk("rst_rv", {31'b0, rv}, 32'h0);
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_b1", {31'b0, b1}, 32'h0);

    // 1: read r5 / r31 after reset
    rst = 1'b0;
    read_enable = 1'b1; read_register1 = 5'd5; read_register2 = 5'd31;
    step();
    chk("t1_rv", {31'b0, rv}, 32'h1);
    chk("t1_rd1", rd1, 32'h0);
    chk("t1_rd2", rd2, 32'h0);
    chk("t1_busy", {30'b0, b1, b2}, 32'h0);
    idle();
    step();
    chk("t1_rv_drop", {31'b0, rv}, 32'h0);

    // 2: write r7, read on both ports next cycle
    reg_write = 1'b1; write_register = 5'd7; write_data = 32'hDEADBEEF;
    step();
    idle();
    read_enable = 1'b1; read_register1 = 5'd7; read_register2 = 5'd7;
    step();
    chk("t2_rd1", rd1, 32'hDEADBEEF);
    chk("t2_rd2", rd2, 32'hDEADBEEF);
    chk("t2_rv", {31'b0, rv}, 32'h1);

    // 3: bypass vs. pre-write value
    idle();
    reg_write = 1'b1; write_register = 5'd3; write_data = 32'h00001111;
    step();
    write_data = 32'h12345678;
    read_enable = 1'b1; read_register1 = 5'd3; read_register2 = 5'd3;
    step();
    chk("t3_byp_rd1", rd1, 32'h12345678);
    chk("t3_byp_rd2", rd2, 32'h12345678);
    chk("t3_nobyp_rd1", nb_rd1, 32'h00001111);
    idle();
    read_enable = 1'b1;
    step();
    chk("t3_nobyp_after", nb_rd2, 32'h12345678);

    // 4: zero register
    idle();
    reg_write = 1'b1; write_register = 5'd0; write_data = 32'hFFFFFFFF;
    read_enable = 1'b1; read_register1 = 5'd0; read_register2 = 5'd0;
    step();
    chk("t4_r0_rd1", rd1, 32'h0);
    chk("t4_r0_rd2", rd2, 32'h0);
    chk("t4_r0_nb", nb_rd1, 32'h0);
    idle();
    pend_set = 1'b1; pend_register = 5'd0;
    step();
    idle();
    read_enable = 1'b1; read_register1 = 5'd0; read_register2 = 5'd7;
    step();
    chk("t4_r0_busy", {31'b0, b1}, 32'h0);
    chk("t4_r0_stored", rd1, 32'h0);

    // 5: scoreboard
    idle();
    pend_set = 1'b1; pend_register = 5'd9;
    step();
    idle();
    read_enable = 1'b1; read_register1 = 5'd9; read_register2 = 5'd3;
    step();
    chk("t5_busy1", {31'b0, b1}, 32'h1);
    chk("t5_busy2_other", {31'b0, b2}, 32'h0);
    reg_write = 1'b1; write_register = 5'd9; write_data = 32'h000000A5;
    step();
    chk("t5_wb_rd1", rd1, 32'h000000A5);
    chk("t5_wb_busy1", {31'b0, b1}, 32'h0);
    idle();
    pend_set = 1'b1; pend_register = 5'd9;
    reg_write = 1'b1; write_register = 5'd9; write_data = 32'h00000077;
    step();
    idle();
    read_enable = 1'b1; read_register1 = 5'd9; read_register2 = 5'd9;
    step();
    chk("t5_both_busy", {30'b0, b1, b2}, 32'h3);
    chk("t5_both_rd1", rd1, 32'h00000077);
    idle();
    read_register1 = 5'd7;
    step();
    chk("t5_hold_rd1", rd1, 32'h00000077);
    chk("t5_hold_b1", {31'b0, b1}, 32'h1);
    chk("t5_hold_rv", {31'b0, rv}, 32'h0);

    // 6: reset with a read in flight
    read_enable = 1'b1; read_register1 = 5'd7; read_register2 = 5'd9;
    step();
    rst = 1'b1;
    step();
    chk("t6_rv", {31'b0, rv}, 32'h0);
    chk("t6_rd1", rd1, 32'h0);
    chk("t6_rd2", rd2, 32'h0);
    chk("t6_busy", {30'b0, b1, b2}, 32'h0);
    rst = 1'b0;
    step();
    chk("t6_r7_cleared", rd1, 32'h0);
    chk("t6_r9_not_busy", {31'b0, b2}, 32'h0);
    chk("t6_rv_after", {31'b0, rv}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
